// File: rtl/fetch_pkg.sv
// Shared types and constants for the IF->ID instruction queue.
// Entry layout is {pc, instr}; NOP is the canonical addi x0,x0,0.
package fetch_pkg;
    localparam int FQ_XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [FQ_XLEN-1:0] pc;
        logic [FQ_XLEN-1:0] instr;
    } fq_entry_t;
endpackage

// File: rtl/fq_ptr_ctrl.sv
// Purpose: read/write pointers and occupancy for the fetch queue, flush > push/pop.
// Latency: pointer and count updates take effect on the rising edge after the handshake.
// Backpressure: push refused while FULL, pop refused while EMPTY; flush drops both.
module fq_ptr_ctrl #(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_req,
    input  logic          pop_req,
    input  logic          flush,
    output logic [PW-1:0] wr_ptr,
    output logic [PW-1:0] rd_ptr,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          push_ok
);
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pop_ok;

    // Acceptance depends only on registered occupancy, so a pop cannot make room for a same-cycle push.
    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push_req & ~full;
    assign pop_ok  = pop_req & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
            else if (pop_ok && !push_ok) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_ptr = wr_ptr_q;
    assign rd_ptr = rd_ptr_q;
    assign count  = count_q;
endmodule

// File: rtl/fetch_queue.sv
// Purpose: instruction buffer decoupling IF from ID stalls, squashed on redirect.
// Latency: an accepted entry appears at the ID outputs one cycle after the push (no bypass).
// Backpressure: if_ready low only when FULL; id_ready low holds the head stable.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = FQ_XLEN
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     if_valid,
    output logic                     if_ready,
    input  logic [XLEN-1:0]          if_pc,
    input  logic [XLEN-1:0]          if_instr,
    output logic                     id_valid,
    input  logic                     id_ready,
    output logic [XLEN-1:0]          id_pc,
    output logic [XLEN-1:0]          id_pc_plus4,
    output logic [XLEN-1:0]          id_instr,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          full, empty, push_ok;
    fq_entry_t     mem_q [DEPTH];
    fq_entry_t     mem_d [DEPTH];
    fq_entry_t     head;

    fq_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_req (if_valid),
        .pop_req  (id_ready),
        .flush    (flush),
        .wr_ptr   (wr_ptr),
        .rd_ptr   (rd_ptr),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .push_ok  (push_ok)
    );

    always_comb begin
        mem_d = mem_q;
        if (push_ok && !flush) begin
            mem_d[wr_ptr].pc    = FQ_XLEN'(if_pc);
            mem_d[wr_ptr].instr = FQ_XLEN'(if_instr);
        end
    end

    // Data array is deliberately unreset; id_valid gates everything visible downstream.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head     = mem_q[rd_ptr];
    assign if_ready = ~full;
    assign id_valid = ~empty;

    always_comb begin
        id_pc    = '0;
        id_instr = XLEN'(NOP_INSTR);
        if (id_valid) begin
            id_pc    = XLEN'(head.pc);
            id_instr = XLEN'(head.instr);
        end
    end

    assign id_pc_plus4 = id_pc + XLEN'(4);
endmodule

// File: tb/tb_fetch_queue.sv
// Scenario bench for fetch_queue: scoreboard of accepted entries checked at the ID head.
module tb_fetch_queue;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            if_valid, if_ready, id_valid, id_ready, flush;
    logic [XLEN-1:0] if_pc, if_instr, id_pc, id_pc_plus4, id_instr;
    logic [2:0]      count;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t sb[$];
    int   m_count;
    int   tests_run;
    int   tests_failed;

    fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_pc       (if_pc),
        .if_instr    (if_instr),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_pc       (id_pc),
        .id_pc_plus4 (id_pc_plus4),
        .id_instr    (id_instr),
        .flush       (flush),
        .count       (count)
    );

    always #5 clk = ~clk;

    // Advance one clock and update the reference model from the inputs driven this cycle.
    task automatic step();
        bit   push, pop;
        exp_t e;
        push    = if_valid && (m_count != DEPTH);
        pop     = id_ready && (m_count != 0);
        e.pc    = if_pc;
        e.instr = if_instr;
        @(posedge clk);
        #1;
        if (flush) begin
            sb.delete();
        end else begin
            if (pop)  void'(sb.pop_front());
            if (push) sb.push_back(e);
        end
        m_count = sb.size();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; if_valid = 1'b1; if_pc = 32'h40; if_instr = 32'h00100093;
        id_ready = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (id_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_id_valid got %0b exp 0", id_valid); end
        tests_run++;
        if (id_instr !== NOP) begin tests_failed++; $display("FAIL reset_id_instr got %h exp %h", id_instr, NOP); end
        tests_run++;
        if (if_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_if_ready got %0b exp 1", if_ready); end
        tests_run++;
        if (count !== 3'd0) begin tests_failed++; $display("FAIL reset_count got %0d exp 0", count); end
        tests_run++;
        if (id_pc !== 32'h0 || id_pc_plus4 !== 32'h4) begin
            tests_failed++; $display("FAIL reset_pc got %h/%h exp 0/4", id_pc, id_pc_plus4);
        end
        if_valid = 1'b0;
        rst_n    = 1'b1;
        sb.delete();
        m_count = 0;
    endtask

    task automatic test_single_push();
        if_valid = 1'b1; if_pc = 32'h100; if_instr = 32'h00500093;
        #1;
        tests_run++;
        if (id_valid !== 1'b0) begin tests_failed++; $display("FAIL push_no_bypass id_valid got %0b exp 0", id_valid); end
        step();
        if_valid = 1'b0;
        #1;
        tests_run++;
        if (id_valid !== 1'b1 || id_pc !== sb[0].pc || id_instr !== sb[0].instr) begin
            tests_failed++;
            $display("FAIL push_head got v=%0b pc=%h ins=%h exp v=1 pc=%h ins=%h", id_valid, id_pc, id_instr, sb[0].pc, sb[0].instr);
        end
        tests_run++;
        if (id_pc_plus4 !== 32'h104) begin tests_failed++; $display("FAIL push_pc_plus4 got %h exp 104", id_pc_plus4); end
        id_ready = 1'b1;
        step();
        id_ready = 1'b0;
        #1;
        tests_run++;
        if (count !== 3'd0 || id_instr !== NOP) begin
            tests_failed++; $display("FAIL push_pop_empty got cnt=%0d ins=%h exp cnt=0 ins=%h", count, id_instr, NOP);
        end
    endtask

    task automatic test_fill_stall();
        id_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if_valid = 1'b1; if_pc = 32'(i * 4); if_instr = 32'h00000093 | 32'(i << 20);
            #1;
            tests_run++;
            if (if_ready !== 1'b1) begin tests_failed++; $display("FAIL fill_if_ready[%0d] got %0b exp 1", i, if_ready); end
            step();
        end
        tests_run++;
        if (count !== 3'(m_count) || if_ready !== 1'b0) begin
            tests_failed++; $display("FAIL fill_full got cnt=%0d rdy=%0b exp cnt=%0d rdy=0", count, if_ready, m_count);
        end
        if_pc = 32'h99; if_instr = 32'hdeadbeef;
        step();
        if_valid = 1'b0;
        #1;
        tests_run++;
        if (count !== 3'd4 || id_pc !== 32'h0 || id_pc !== sb[0].pc) begin
            tests_failed++; $display("FAIL fill_fifth_push got cnt=%0d head=%h exp cnt=4 head=0", count, id_pc);
        end
    endtask

    task automatic test_drain_wrap();
        logic [31:0] offers [2];
        int          next_offer;
        int          pops;
        offers[0] = 32'h10; offers[1] = 32'h14;
        next_offer = 0;
        pops = 0;
        id_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && (sb.size() != 0 || next_offer < 2); cyc++) begin
            if_valid = (next_offer < 2);
            if (next_offer < 2) begin
                if_pc    = offers[next_offer];
                if_instr = 32'h00700113 + offers[next_offer];
            end
            #1;
            tests_run++;
            if (if_ready !== (m_count != DEPTH)) begin
                tests_failed++; $display("FAIL drain_if_ready cyc %0d got %0b exp %0b", cyc, if_ready, m_count != DEPTH);
            end
            if (m_count != 0) begin
                tests_run++;
                if (id_valid !== 1'b1 || id_pc !== sb[0].pc || id_instr !== sb[0].instr) begin
                    tests_failed++;
                    $display("FAIL drain_order cyc %0d got pc=%h ins=%h exp pc=%h ins=%h", cyc, id_pc, id_instr, sb[0].pc, sb[0].instr);
                end
                pops++;
            end
            if (if_valid && m_count != DEPTH) next_offer++;
            step();
        end
        if_valid = 1'b0;
        id_ready = 1'b0;
        #1;
        tests_run++;
        if (pops !== 6 || count !== 3'd0 || id_valid !== 1'b0) begin
            tests_failed++; $display("FAIL drain_total got pops=%0d cnt=%0d exp pops=6 cnt=0", pops, count);
        end
    endtask

    task automatic test_flush();
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if_valid = 1'b1; if_pc = 32'h200 + 32'(i * 4); if_instr = 32'h00a00513;
            step();
        end
        tests_run++;
        if (count !== 3'd3) begin tests_failed++; $display("FAIL flush_setup_count got %0d exp 3", count); end
        flush = 1'b1; if_valid = 1'b1; if_pc = 32'h500; id_ready = 1'b1;
        step();
        flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
        #1;
        tests_run++;
        if (count !== 3'd0 || id_valid !== 1'b0 || id_instr !== NOP) begin
            tests_failed++; $display("FAIL flush_clear got cnt=%0d v=%0b ins=%h exp cnt=0 v=0 ins=%h", count, id_valid, id_instr, NOP);
        end
        step();
        tests_run++;
        if (count !== 3'(m_count) || id_valid !== 1'b0) begin
            tests_failed++; $display("FAIL flush_push_dropped got cnt=%0d v=%0b exp cnt=0 v=0", count, id_valid);
        end
    endtask

    task automatic test_async_reset();
        id_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if_valid = 1'b1; if_pc = 32'h300 + 32'(i * 4); if_instr = 32'h00b00593;
            step();
        end
        if_valid = 1'b0;
        tests_run++;
        if (count !== 3'd2 || id_pc !== 32'h300) begin
            tests_failed++; $display("FAIL areset_setup got cnt=%0d head=%h exp cnt=2 head=300", count, id_pc);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (id_valid !== 1'b0 || count !== 3'd0 || if_ready !== 1'b1) begin
            tests_failed++; $display("FAIL areset_immediate got v=%0b cnt=%0d rdy=%0b exp v=0 cnt=0 rdy=1", id_valid, count, if_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        m_count = 0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        m_count      = 0;
        rst_n = 1'b0; if_valid = 1'b0; id_ready = 1'b0; flush = 1'b0;
        if_pc = '0; if_instr = '0;
        test_reset();
        test_single_push();
        test_fill_stall();
        test_drain_wrap();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
